// File: rtl/ss_pop_unit_pkg.sv
// Shadow-stack pop unit: shared types, constants and helpers.
// Imported by the pop FSM and its bench.
package ss_pop_unit_pkg;

  localparam int unsigned SS_XLEN     = 64;
  localparam int unsigned SS_VLEN     = 64;
  localparam int unsigned SS_PLEN     = 56;
  localparam int unsigned SS_TID_BITS = 3;

  localparam logic [63:0] SW_CHECK_CAUSE = 64'd18;
  localparam logic [63:0] SS_TVAL        = 64'd3;
  localparam logic [63:0] LD_MISAL_CAUSE = 64'd4;

  localparam logic [SS_VLEN-1:0] SS_ALIGN_MASK =
    SS_VLEN'((SS_XLEN / 8) - 1);

  typedef enum logic {
    SSPOP    = 1'b0,
    SSPOPCHK = 1'b1
  } ss_pop_op_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TRANS,
    WAIT_GNT,
    WAIT_RVALID,
    DRAIN
  } ss_pop_state_e;

  function automatic logic ss_addr_misaligned(
    input logic [SS_VLEN-1:0] vaddr
  );
    return (vaddr & SS_ALIGN_MASK) != '0;
  endfunction

endpackage

// File: rtl/ss_pop_unit.sv
// Shadow-stack reader: translate, load one word, return it or
// compare it against the link register and trap on mismatch.
module ss_pop_unit
  import ss_pop_unit_pkg::*;
#(
  parameter int unsigned XLEN          = SS_XLEN,
  parameter int unsigned VLEN          = SS_VLEN,
  parameter int unsigned PLEN          = SS_PLEN,
  parameter int unsigned TRANS_ID_BITS = SS_TID_BITS
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic                     chk_i,
  input  logic [VLEN-1:0]          vaddr_i,
  input  logic [XLEN-1:0]          expected_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     translation_req_o,
  output logic [VLEN-1:0]          vaddr_o,
  input  logic                     dtlb_hit_i,
  input  logic [PLEN-1:0]          paddr_i,
  input  logic                     ex_valid_i,
  input  logic [XLEN-1:0]          ex_cause_i,
  output logic                     ld_req_o,
  output logic [PLEN-1:0]          ld_addr_o,
  input  logic                     ld_gnt_i,
  output logic                     ld_kill_o,
  input  logic                     ld_rvalid_i,
  input  logic [XLEN-1:0]          ld_rdata_i,
  output logic                     valid_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o,
  output logic [XLEN-1:0]          result_o,
  output logic                     ex_valid_o,
  output logic [XLEN-1:0]          ex_cause_o,
  output logic [XLEN-1:0]          ex_tval_o,
  output logic                     ssp_incr_o
);

  ss_pop_state_e            r_state;
  ss_pop_state_e            w_next;
  ss_pop_op_t               r_op;
  logic [VLEN-1:0]          r_vaddr;
  logic [XLEN-1:0]          r_expected;
  logic [TRANS_ID_BITS-1:0] r_trans_id;
  logic [PLEN-1:0]          r_paddr;

  logic                     r_valid;
  logic [TRANS_ID_BITS-1:0] r_rsp_id;
  logic [XLEN-1:0]          r_result;
  logic                     r_ex_valid;
  logic [XLEN-1:0]          r_ex_cause;
  logic [XLEN-1:0]          r_ex_tval;
  logic                     r_ssp_incr;

  logic                     w_accept;
  logic                     w_paddr_en;
  logic                     w_misaligned;
  logic                     w_match;
  logic                     w_rsp_valid;
  logic [TRANS_ID_BITS-1:0] w_rsp_id;
  logic [XLEN-1:0]          w_rsp_result;
  logic                     w_rsp_ex;
  logic [XLEN-1:0]          w_rsp_cause;
  logic [XLEN-1:0]          w_rsp_tval;
  logic                     w_rsp_incr;

  assign w_misaligned = ss_addr_misaligned(vaddr_i);
  assign w_match      = (ld_rdata_i == r_expected);

  always_comb begin
    w_next            = r_state;
    ready_o           = 1'b0;
    translation_req_o = 1'b0;
    vaddr_o           = '0;
    ld_req_o          = 1'b0;
    ld_addr_o         = '0;
    ld_kill_o         = 1'b0;
    w_accept          = 1'b0;
    w_paddr_en        = 1'b0;
    w_rsp_valid       = 1'b0;
    w_rsp_id          = r_trans_id;
    w_rsp_result      = '0;
    w_rsp_ex          = 1'b0;
    w_rsp_cause       = '0;
    w_rsp_tval        = '0;
    w_rsp_incr        = 1'b0;

    unique case (r_state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i && !flush_i) begin
          w_accept = 1'b1;
          w_rsp_id = trans_id_i;
          if (w_misaligned) begin
            w_rsp_valid = 1'b1;
            w_rsp_ex    = 1'b1;
            w_rsp_cause = XLEN'(LD_MISAL_CAUSE);
            w_rsp_tval  = XLEN'(vaddr_i);
          end else begin
            translation_req_o = 1'b1;
            vaddr_o           = vaddr_i;
            if (ex_valid_i) begin
              w_rsp_valid = 1'b1;
              w_rsp_ex    = 1'b1;
              w_rsp_cause = ex_cause_i;
              w_rsp_tval  = XLEN'(vaddr_i);
            end else if (dtlb_hit_i) begin
              w_paddr_en = 1'b1;
              w_next     = WAIT_GNT;
            end else begin
              w_next = WAIT_TRANS;
            end
          end
        end
      end

      WAIT_TRANS: begin
        if (flush_i) begin
          w_next = IDLE;
        end else begin
          translation_req_o = 1'b1;
          vaddr_o           = r_vaddr;
          if (ex_valid_i) begin
            w_rsp_valid = 1'b1;
            w_rsp_ex    = 1'b1;
            w_rsp_cause = ex_cause_i;
            w_rsp_tval  = XLEN'(r_vaddr);
            w_next      = IDLE;
          end else if (dtlb_hit_i) begin
            w_paddr_en = 1'b1;
            w_next     = WAIT_GNT;
          end
        end
      end

      WAIT_GNT: begin
        ld_req_o  = 1'b1;
        ld_addr_o = r_paddr;
        // A grant racing a flush still leaves a load in flight.
        if (flush_i) begin
          if (ld_gnt_i) begin
            ld_kill_o = 1'b1;
            w_next    = DRAIN;
          end else begin
            w_next = IDLE;
          end
        end else if (ld_gnt_i) begin
          w_next = WAIT_RVALID;
        end
      end

      WAIT_RVALID: begin
        if (flush_i) begin
          if (ld_rvalid_i) begin
            w_next = IDLE;
          end else begin
            ld_kill_o = 1'b1;
            w_next    = DRAIN;
          end
        end else if (ld_rvalid_i) begin
          w_rsp_valid = 1'b1;
          w_next      = IDLE;
          if (r_op == SSPOP) begin
            w_rsp_result = ld_rdata_i;
            w_rsp_incr   = 1'b1;
          end else if (w_match) begin
            w_rsp_incr = 1'b1;
          end else begin
            w_rsp_ex    = 1'b1;
            w_rsp_cause = XLEN'(SW_CHECK_CAUSE);
            w_rsp_tval  = XLEN'(SS_TVAL);
          end
        end
      end

      DRAIN: begin
        if (ld_rvalid_i) begin
          w_next = IDLE;
        end
      end

      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_op       <= SSPOP;
      r_vaddr    <= '0;
      r_expected <= '0;
      r_trans_id <= '0;
      r_paddr    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op       <= ss_pop_op_t'(chk_i);
        r_vaddr    <= vaddr_i;
        r_expected <= expected_i;
        r_trans_id <= trans_id_i;
      end
      if (w_paddr_en) begin
        r_paddr <= paddr_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid    <= 1'b0;
      r_rsp_id   <= '0;
      r_result   <= '0;
      r_ex_valid <= 1'b0;
      r_ex_cause <= '0;
      r_ex_tval  <= '0;
      r_ssp_incr <= 1'b0;
    end else begin
      r_valid    <= w_rsp_valid;
      r_rsp_id   <= w_rsp_valid ? w_rsp_id : '0;
      r_result   <= w_rsp_result;
      r_ex_valid <= w_rsp_ex;
      r_ex_cause <= w_rsp_cause;
      r_ex_tval  <= w_rsp_tval;
      r_ssp_incr <= w_rsp_incr;
    end
  end

  assign valid_o    = r_valid;
  assign trans_id_o = r_rsp_id;
  assign result_o   = r_result;
  assign ex_valid_o = r_ex_valid;
  assign ex_cause_o = r_ex_cause;
  assign ex_tval_o  = r_ex_tval;
  assign ssp_incr_o = r_ssp_incr;

endmodule

// File: tb/tb_ss_pop_unit.sv
// Directed bench for the shadow-stack pop unit.
// Small MMU/D$ responder driven from per-op latency knobs.
module tb_ss_pop_unit;
  import ss_pop_unit_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        chk_i = 1'b0;
  logic [63:0] vaddr_i = '0;
  logic [63:0] expected_i = '0;
  logic [2:0]  trans_id_i = '0;
  logic        translation_req_o;
  logic [63:0] vaddr_o;
  logic        dtlb_hit_i = 1'b0;
  logic [55:0] paddr_i = '0;
  logic        ex_valid_i = 1'b0;
  logic [63:0] ex_cause_i = '0;
  logic        ld_req_o;
  logic [55:0] ld_addr_o;
  logic        ld_gnt_i = 1'b0;
  logic        ld_kill_o;
  logic        ld_rvalid_i = 1'b0;
  logic [63:0] ld_rdata_i = '0;
  logic        valid_o;
  logic [2:0]  trans_id_o;
  logic [63:0] result_o;
  logic        ex_valid_o;
  logic [63:0] ex_cause_o;
  logic [63:0] ex_tval_o;
  logic        ssp_incr_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  ss_pop_unit dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .flush_i           (flush_i),
    .valid_i           (valid_i),
    .ready_o           (ready_o),
    .chk_i             (chk_i),
    .vaddr_i           (vaddr_i),
    .expected_i        (expected_i),
    .trans_id_i        (trans_id_i),
    .translation_req_o (translation_req_o),
    .vaddr_o           (vaddr_o),
    .dtlb_hit_i        (dtlb_hit_i),
    .paddr_i           (paddr_i),
    .ex_valid_i        (ex_valid_i),
    .ex_cause_i        (ex_cause_i),
    .ld_req_o          (ld_req_o),
    .ld_addr_o         (ld_addr_o),
    .ld_gnt_i          (ld_gnt_i),
    .ld_kill_o         (ld_kill_o),
    .ld_rvalid_i       (ld_rvalid_i),
    .ld_rdata_i        (ld_rdata_i),
    .valid_o           (valid_o),
    .trans_id_o        (trans_id_o),
    .result_o          (result_o),
    .ex_valid_o        (ex_valid_o),
    .ex_cause_o        (ex_cause_o),
    .ex_tval_o         (ex_tval_o),
    .ssp_incr_o        (ssp_incr_o)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    valid_i     = 1'b0;
    flush_i     = 1'b0;
    dtlb_hit_i  = 1'b0;
    ex_valid_i  = 1'b0;
    ld_gnt_i    = 1'b0;
    ld_rvalid_i = 1'b0;
  endtask

  // One op against a responder: TLB misses for `miss` cycles, D$
  // grants on the (gdly+1)th request cycle, data the cycle after.
  task automatic run_op(
    input string       tag,
    input logic        c,
    input logic [63:0] va,
    input logic [63:0] ex,
    input logic [2:0]  id,
    input int          miss,
    input int          gdly,
    input logic        pf,
    input logic [63:0] rd,
    input int          e_lat,
    input logic [63:0] e_res,
    input logic        e_exv,
    input logic [63:0] e_cause,
    input logic [63:0] e_tval,
    input logic        e_incr,
    input int          e_trq,
    input int          e_lrq
  );
    int t, gt, lat, trq, lrq;
    logic [63:0] o_res, o_cause, o_tval;
    logic        o_exv, o_incr;
    logic [2:0]  o_id;
    t = 0; gt = -1; lat = -1; trq = 0; lrq = 0;
    o_res = '0; o_cause = '0; o_tval = '0;
    o_exv = 1'b0; o_incr = 1'b0; o_id = '0;
    chk_i      = c;
    vaddr_i    = va;
    expected_i = ex;
    trans_id_i = id;
    paddr_i    = va[55:0];
    ex_cause_i = 64'd13;
    ld_rdata_i = rd;
    while (lat < 0 && t < 40) begin
      @(negedge clk_i);
      valid_i     = (t == 0);
      dtlb_hit_i  = (t >= miss);
      ex_valid_i  = pf && (t == 0);
      ld_gnt_i    = 1'b0;
      ld_rvalid_i = (gt >= 0) && (t == gt + 1);
      #1;
      if (valid_o) begin
        lat = t;
        o_res = result_o; o_exv = ex_valid_o;
        o_cause = ex_cause_o; o_tval = ex_tval_o;
        o_incr = ssp_incr_o; o_id = trans_id_o;
      end
      if (translation_req_o) trq++;
      if (ld_req_o) begin
        if (lrq == gdly) begin
          ld_gnt_i = 1'b1;
          gt = t;
        end
        lrq++;
      end
      #1;
      t++;
    end
    @(negedge clk_i);
    idle_inputs();
    #1;
    chk({tag, ".lat"},   64'(lat),   64'(e_lat));
    chk({tag, ".res"},   o_res,      e_res);
    chk({tag, ".exv"},   64'(o_exv), 64'(e_exv));
    chk({tag, ".cause"}, o_cause,    e_cause);
    chk({tag, ".tval"},  o_tval,     e_tval);
    chk({tag, ".incr"},  64'(o_incr), 64'(e_incr));
    chk({tag, ".id"},    64'(o_id),  64'(id));
    chk({tag, ".trq"},   64'(trq),   64'(e_trq));
    chk({tag, ".lrq"},   64'(lrq),   64'(e_lrq));
    chk({tag, ".pulse"}, 64'(valid_o), 64'd0);
    chk({tag, ".rdy"},   64'(ready_o), 64'd1);
  endtask

  initial begin
    int vcnt, icnt;
    vcnt = 0; icnt = 0;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst.ready", 64'(ready_o), 64'd1);
    chk("rst.valid", 64'(valid_o), 64'd0);
    chk("rst.treq",  64'(translation_req_o), 64'd0);
    chk("rst.ldreq", 64'(ld_req_o), 64'd0);
    chk("rst.incr",  64'(ssp_incr_o), 64'd0);
    chk("rst.res",   result_o, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    run_op("pop", 1'b0, 64'h8000_0FF8, 64'h0, 3'd5, 0, 0, 1'b0,
           64'h8000_1234, 3, 64'h8000_1234, 1'b0, 64'h0, 64'h0,
           1'b1, 1, 1);
    run_op("chk_ok", 1'b1, 64'h8000_0FF0, 64'h1000_0040, 3'd2,
           0, 0, 1'b0, 64'h1000_0040, 3, 64'h0, 1'b0, 64'h0,
           64'h0, 1'b1, 1, 1);
    run_op("chk_bad", 1'b1, 64'h8000_0FF0, 64'h1000_0040, 3'd3,
           0, 0, 1'b0, 64'h1000_0044, 3, 64'h0, 1'b1, 64'd18,
           64'd3, 1'b0, 1, 1);
    run_op("slow", 1'b0, 64'h8000_2000, 64'h0, 3'd6, 4, 2, 1'b0,
           64'hDEAD_BEEF_0000_0008, 9, 64'hDEAD_BEEF_0000_0008,
           1'b0, 64'h0, 64'h0, 1'b1, 5, 3);
    run_op("misal", 1'b0, 64'h8000_0FFC, 64'h0, 3'd1, 0, 0, 1'b0,
           64'h0, 1, 64'h0, 1'b1, 64'd4, 64'h8000_0FFC,
           1'b0, 0, 0);
    run_op("pf", 1'b0, 64'h8000_3000, 64'h0, 3'd7, 0, 0, 1'b1,
           64'h0, 1, 64'h0, 1'b1, 64'd13, 64'h8000_3000,
           1'b0, 1, 0);

    // Flush one cycle after grant; data arrives two cycles later.
    @(negedge clk_i);
    chk_i = 1'b0; vaddr_i = 64'h8000_4000; paddr_i = 56'h4000;
    trans_id_i = 3'd4; ld_rdata_i = 64'h55;
    valid_i = 1'b1; dtlb_hit_i = 1'b1;
    @(negedge clk_i);
    idle_inputs();
    ld_gnt_i = 1'b1;
    #1;
    chk("fl.ldreq", 64'(ld_req_o), 64'd1);
    chk("fl.ldaddr", 64'(ld_addr_o), 64'h4000);
    @(negedge clk_i);
    idle_inputs();
    flush_i = 1'b1;
    #1;
    chk("fl.kill", 64'(ld_kill_o), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      idle_inputs();
      ld_rvalid_i = (k == 1);
      #1;
      if (ld_kill_o) icnt++;
      if (valid_o || ssp_incr_o) vcnt++;
      if (k == 0) chk("fl.busy", 64'(ready_o), 64'd0);
      if (k == 2) chk("fl.ready", 64'(ready_o), 64'd1);
    end
    chk("fl.killone", 64'(icnt), 64'd0);
    chk("fl.noresp", 64'(vcnt), 64'd0);

    // Reset mid-operation returns the unit to IDLE at once.
    @(negedge clk_i);
    idle_inputs();
    vaddr_i = 64'h8000_5000; valid_i = 1'b1;
    @(negedge clk_i);
    idle_inputs();
    #1;
    chk("mr.busy", 64'(ready_o), 64'd0);
    rst_ni = 1'b0;
    #1;
    chk("mr.ready", 64'(ready_o), 64'd1);
    chk("mr.treq", 64'(translation_req_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
